// File: rtl/eth_intr_gen.sv
// rtl/eth_intr_gen.sv - Ethernet MAC interrupt source/mask block with Wishbone slave port
// Optional holdoff coalescing of wb_intr: define ETH_INTR_COALESCE_EN.
module eth_intr_gen #(
  parameter int NUM_SRC   = 7,
  parameter int HOLDOFF_W = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic [NUM_SRC-1:0] ev_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_intr
);

  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] set;
  logic               acc;
  logic               wr;
  logic               pend;
  logic [31:0]        rdata;
  logic               unused;

  assign acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = acc & wb_we_i;
  assign w1c    = (wr && wb_adr_i == 2'd0 && wb_sel_i[0]) ? wb_dat_i[NUM_SRC-1:0] : '0;
  assign set    = (wr && wb_adr_i == 2'd2 && wb_sel_i[0]) ? wb_dat_i[NUM_SRC-1:0] : '0;
  assign pend   = |(src & mask);
  assign unused = ^{wb_sel_i[3:1], wb_dat_i[31:NUM_SRC]};

`ifdef ETH_INTR_COALESCE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ASSERT} state_t;
  localparam logic [HOLDOFF_W-1:0] HOLD_ONE = 1;

  state_t               state;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [HOLDOFF_W-1:0] cnt;
  logic [HOLDOFF_W-1:0] hold_be;

  // Byte lane enables for the HOLDOFF register (sel[0] low byte, sel[1] high byte).
  always_comb begin
    hold_be = '0;
    for (int i = 0; i < HOLDOFF_W; i++) begin
      if (i < 8)       hold_be[i] = wb_sel_i[0];
      else if (i < 16) hold_be[i] = wb_sel_i[1];
      else             hold_be[i] = 1'b0;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      2'd0: if (wb_sel_i[0]) rdata[NUM_SRC-1:0] = src;
      2'd1: if (wb_sel_i[0]) rdata[NUM_SRC-1:0] = mask;
`ifdef ETH_INTR_COALESCE_EN
      2'd3: begin
        for (int i = 0; i < HOLDOFF_W; i++) begin
          rdata[i] = holdoff[i] & hold_be[i];
        end
      end
`endif
      default: rdata = '0;
    endcase
  end

  // Event or INT_SET in the same cycle as a W1C of that bit keeps it set.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      src      <= '0;
      mask     <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      src      <= (src & ~w1c) | ev_i | set;
      if (wr && wb_adr_i == 2'd1 && wb_sel_i[0]) begin
        mask <= wb_dat_i[NUM_SRC-1:0];
      end
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rdata : '0;
    end
  end

`ifdef ETH_INTR_COALESCE_EN
  // A HOLDOFF write only affects the next count load, never a running count.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      holdoff <= '0;
      wb_intr <= 1'b0;
    end else begin
      if (wr && wb_adr_i == 2'd3) begin
        holdoff <= (holdoff & ~hold_be) | (wb_dat_i[HOLDOFF_W-1:0] & hold_be);
      end
      case (state)
        ST_IDLE: begin
          if (pend) begin
            if (holdoff == '0) begin
              state   <= ST_ASSERT;
              wb_intr <= 1'b1;
            end else begin
              cnt   <= holdoff - HOLD_ONE;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!pend) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state   <= ST_ASSERT;
            wb_intr <= 1'b1;
          end else begin
            cnt <= cnt - HOLD_ONE;
          end
        end
        ST_ASSERT: begin
          if (!pend) begin
            state   <= ST_IDLE;
            wb_intr <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          wb_intr <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wb_intr <= 1'b0;
    end else begin
      wb_intr <= pend;
    end
  end
`endif

endmodule

// File: tb/tb_eth_intr_gen.sv
// tb/tb_eth_intr_gen.sv - self-checking bench for eth_intr_gen
`timescale 1ns/1ps
module tb_eth_intr_gen;
  localparam int NUM_SRC   = 7;
  localparam int HOLDOFF_W = 16;

  logic               wb_clk   = 1'b0;
  logic               wb_rst   = 1'b0;
  logic [NUM_SRC-1:0] ev_i     = '0;
  logic               wb_cyc_i = 1'b0;
  logic               wb_stb_i = 1'b0;
  logic               wb_we_i  = 1'b0;
  logic [1:0]         wb_adr_i = '0;
  logic [3:0]         wb_sel_i = '0;
  logic [31:0]        wb_dat_i = '0;
  logic [31:0]        wb_dat_o;
  logic               wb_ack_o;
  logic               wb_intr;

  int checks   = 0;
  int failures = 0;

  // Reference model state: register contents plus length of the current pending run.
  int unsigned m_src, m_mask, m_hold, m_run, m_run_hold, m_dat;
  bit          m_ack, m_intr;

  eth_intr_gen #(.NUM_SRC(NUM_SRC), .HOLDOFF_W(HOLDOFF_W)) dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .ev_i    (ev_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_intr (wb_intr)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock with the inputs currently driven; model predicts the edge.
  task automatic step();
    bit          acc, wr0;
    int unsigned clr, set, rdat, pend;
    acc  = wb_cyc_i && wb_stb_i && !m_ack;
    wr0  = acc && wb_we_i && wb_sel_i[0];
    clr  = (wr0 && wb_adr_i == 2'd0) ? (wb_dat_i & 32'h7F) : 0;
    set  = (wr0 && wb_adr_i == 2'd2) ? (wb_dat_i & 32'h7F) : 0;
    case (wb_adr_i)
      2'd0:    rdat = m_src;
      2'd1:    rdat = m_mask;
      2'd3:    rdat = m_hold;
      default: rdat = 0;
    endcase
    pend = m_src & m_mask;
    if (pend != 0) begin
      if (m_run == 0) m_run_hold = m_hold;
      m_run++;
    end else begin
      m_run = 0;
    end
    m_intr = (pend != 0) && (m_run >= m_run_hold + 1);
    if (wr0 && wb_adr_i == 2'd1) m_mask = wb_dat_i & 32'h7F;
`ifdef ETH_INTR_COALESCE_EN
    if (acc && wb_we_i && wb_adr_i == 2'd3) begin
      if (wb_sel_i[0]) m_hold = (m_hold & 32'hFF00) | (wb_dat_i & 32'h00FF);
      if (wb_sel_i[1]) m_hold = (m_hold & 32'h00FF) | (wb_dat_i & 32'hFF00);
    end
`endif
    m_src = ((m_src & ~clr) | 32'(ev_i) | set) & 32'h7F;
    m_dat = (acc && !wb_we_i) ? rdat : 0;
    m_ack = acc;
    @(posedge wb_clk);
    @(negedge wb_clk);
    chk("ack", wb_ack_o, 32'(m_ack));
    chk("intr", wb_intr, 32'(m_intr));
    if (m_ack) chk("dat_o", wb_dat_o, m_dat);
  endtask

  task automatic bus(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd);
    if (m_ack) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      step();
    end
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = 4'hF;
    step();
    rd       = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, adr, dat, d);
  endtask

  task automatic rd(input logic [1:0] adr, output logic [31:0] d);
    bus(1'b0, adr, 32'h0, d);
  endtask

  task automatic do_reset();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    ev_i     = '0;
    wb_rst   = 1'b0;
    #1;
    chk("rst_intr", wb_intr, 32'h0);
    chk("rst_ack", wb_ack_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    m_src = 0; m_mask = 0; m_hold = 0; m_run = 0; m_run_hold = 0;
    m_dat = 0; m_ack = 0; m_intr = 0;
    @(negedge wb_clk);
    wb_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    @(negedge wb_clk);
    do_reset();
    rd(2'd0, d); chk("reset_source", d, 32'h0);
    rd(2'd1, d); chk("reset_mask", d, 32'h0);

    // Basic path
    wr(2'd1, 32'h04);
    ev_i = 7'h04; step(); ev_i = '0;
    chk("basic_lat1", wb_intr, 32'h0);
    step();
    chk("basic_rise", wb_intr, 32'h1);
    rd(2'd0, d); chk("basic_source", d, 32'h04);
    wr(2'd0, 32'h04);
    chk("basic_clr_edge", wb_intr, 32'h1);
    step();
    chk("basic_fall", wb_intr, 32'h0);

    // Masked pending
    wr(2'd1, 32'h0);
    ev_i = 7'h01; step(); ev_i = '0;
    step(); step();
    chk("masked_low", wb_intr, 32'h0);
    rd(2'd0, d); chk("masked_source", d, 32'h01);
    wr(2'd1, 32'h01);
    chk("unmask_edge", wb_intr, 32'h0);
    step();
    chk("unmask_rise", wb_intr, 32'h1);
    wr(2'd0, 32'h01); step(); step();

    // Collision of event with W1C
    wr(2'd1, 32'h02);
    ev_i = 7'h02; step(); ev_i = '0;
    step();
    ev_i = 7'h02; wr(2'd0, 32'h02); ev_i = '0;
    step();
    chk("collide_intr", wb_intr, 32'h1);
    rd(2'd0, d); chk("collide_source", d, 32'h02);
    wr(2'd0, 32'h02); step(); step();
    chk("collide_cleared", wb_intr, 32'h0);

    // Back-to-back reads with strobe held
    step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd1; wb_sel_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b2b_ack", wb_ack_o, 32'((i % 2) == 0));
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wr(2'd2, 32'h60);
    rd(2'd0, d); chk("set_source", d, 32'h60);
    rd(2'd2, d); chk("set_read_zero", d, 32'h0);
    wr(2'd0, 32'h60);

    // Reset mid-operation
    wr(2'd1, 32'h7F);
    ev_i = 7'h04; step(); ev_i = '0;
    step();
    chk("pre_reset_intr", wb_intr, 32'h1);
    do_reset();
    rd(2'd0, d); chk("midrst_source", d, 32'h0);
    rd(2'd1, d); chk("midrst_mask", d, 32'h0);

`ifdef ETH_INTR_COALESCE_EN
    wr(2'd3, 32'd10);
    wr(2'd1, 32'h7F);
    rd(2'd3, d); chk("holdoff_read", d, 32'd10);
    ev_i = 7'h08; step(); ev_i = '0;
    for (int i = 1; i <= 13; i++) begin
      step();
      chk("coal_timing", wb_intr, 32'(i >= 11));
    end
    wr(2'd0, 32'h08); step(); step();
    ev_i = 7'h08; step(); ev_i = '0;
    for (int i = 0; i < 4; i++) step();
    wr(2'd0, 32'h08);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("coal_cancel", wb_intr, 32'h0);
    end
    wr(2'd3, 32'd0);
`else
    wr(2'd3, 32'hFFFF);
    rd(2'd3, d); chk("addr3_zero", d, 32'h0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      ev_i     = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : '0;
      wb_cyc_i = ($urandom_range(0, 2) == 0);
      wb_stb_i = wb_cyc_i;
      wb_we_i  = 1'($urandom_range(0, 1));
      wb_adr_i = 2'($urandom_range(0, 3));
      wb_dat_i = (wb_adr_i == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      wb_sel_i = wb_we_i ? 4'($urandom) : 4'hF;
      step();
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; ev_i = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_intr_gen.md
Name: eth_intr_gen

Overview:
Interrupt source/mask register block for the Ethernet MAC. It latches per-event pulses from the TX/RX datapaths into a sticky INT_SOURCE register, gates them with INT_MASK, and drives the level interrupt wb_intr toward the host/CPU. It is the driving end of the interrupt line that the bench's interrupt monitor waits on. Software accesses it through a Wishbone slave port.

Parameters:
NUM_SRC, 7, number of event sources: bit0 TXB, 1 TXE, 2 RXB, 3 RXE, 4 BUSY, 5 TXC, 6 RXC.
HOLDOFF_W, 16, width of the coalescing holdoff counter (used only with the optional feature).

Ports:
wb_clk  in  1  system clock.
wb_rst  in  1  asynchronous active-low reset.
ev_i  in  NUM_SRC  event pulses, one bit per source; any high cycle sets that source.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  write enable.
wb_adr_i  in  2  word address: 0 INT_SOURCE, 1 INT_MASK, 2 INT_SET, 3 HOLDOFF.
wb_sel_i  in  4  byte selects; only sel[0] matters for 0-2, sel[1:0] for 3.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data, valid while wb_ack_o is high.
wb_ack_o  out  1  single-cycle acknowledge.
wb_intr  out  1  level interrupt, active high, registered.

Behaviour:
- Reset (wb_rst low, asynchronous): INT_SOURCE=0, INT_MASK=0, HOLDOFF=0, wb_ack_o=0, wb_dat_o=0, wb_intr=0, FSM=IDLE.
- Bus: a request is accepted when cyc&stb&!wb_ack_o. wb_ack_o goes high the next cycle, for exactly one cycle. A request held across the ack is re-accepted the cycle after ack drops, so back-to-back accesses complete every 2 cycles. Writes take effect on the accept edge. Read data is sampled on the accept edge.
- INT_SOURCE (addr 0): read returns {0, src[NUM_SRC-1:0]}. A write with sel[0] clears each bit written 1 (W1C).
- INT_MASK (addr 1): read/write, with sel[0]. Bits above NUM_SRC read 0.
- INT_SET (addr 2): a write with sel[0] sets the written-1 bits of INT_SOURCE (software test hook). Reads return 0.
- Per bit, each cycle: next = (src & !w1c) | ev_i | set. A hardware event or INT_SET in the same cycle as a W1C of that bit wins, so the bit stays 1.
- Masking does not block latching; a masked source stays pending and asserts when it is unmasked.
- pend = |(INT_SOURCE & INT_MASK), computed combinationally from the registers.
- Without the optional feature: wb_intr <= pend each cycle. This gives 1-cycle latency from the register update and 2 cycles from an ev_i pulse to wb_intr high. Clearing the last pending bit drops wb_intr one cycle after the clearing write's accept edge.
- Unused addresses or sel bits: writes are ignored and reads return 0. The ack is always given, and no bus error exists.

Optional Feature:
Macro ETH_INTR_COALESCE_EN.
- Defined: HOLDOFF (addr 3) is a read/write register of HOLDOFF_W bits, reset 0. The interrupt is driven by an FSM, and wb_intr is high only in ASSERT.
  - IDLE: if pend and HOLDOFF=0, go to ASSERT. If pend and HOLDOFF≠0, load cnt=HOLDOFF-1 and go to WAIT.
  - WAIT: if !pend, go to IDLE. Else if cnt=0, go to ASSERT. Else cnt-1.
  - ASSERT: stay while pend; go to IDLE when !pend.
  - A HOLDOFF write during WAIT does not alter the running cnt.
  - First event to wb_intr = HOLDOFF+2 cycles when HOLDOFF≠0.
- Undefined: addr 3 reads 0 and writes are ignored. wb_intr follows the plain registered pend path above.

Test Plan:
- Reset mid-operation: set MASK=0x7F, pulse ev_i[2], assert wb_rst low for 1 cycle -> wb_intr=0 immediately; SOURCE reads 0; MASK reads 0.
- Basic path: MASK=0x04, pulse ev_i=0x04 for 1 cycle -> wb_intr high 2 cycles later. Read SOURCE returns 0x04. Write 0x04 to addr 0 -> wb_intr low 1 cycle after the accept edge.
- Masked pending: MASK=0, pulse ev_i[0] -> wb_intr stays 0 and SOURCE=0x01. Write MASK=0x01 -> wb_intr high 1 cycle after the write accept edge.
- Collision: hold ev_i[1]=1 in the exact cycle of a W1C write of 0x02 to addr 0 -> SOURCE still reads 0x02 and wb_intr remains high.
- Bus timing: back-to-back reads with stb held -> each ack is one cycle wide, with one idle cycle between acks. INT_SET write 0x60 -> SOURCE reads 0x60. Read of addr 2 returns 0.
- ETH_INTR_COALESCE_EN, HOLDOFF=10, MASK=0x7F, ev_i[3] pulse -> wb_intr high exactly 12 cycles after the pulse. Repeat with a W1C of bit 3 issued 5 cycles after the pulse -> wb_intr never asserts.
